pixel_pack_rgb888: RTL

//  Write-side counterpart of the RGB888 memory feeder: accepts one RGB888 pixel per beat and packs
//  4 pixels into 3 little-endian 32-bit words (memory image layout), with word-granular write address.

---
 rtl/pixel_pack_rgb888.sv | 106 ++++++++++
 1 files changed

// File: rtl/pixel_pack_rgb888.sv
// pixel_pack_rgb888: packs RGB888 pixels (4 pixels -> 3 little-endian 32-bit words) with frame flush.
// Optional byte-enable output enabled by defining PACK_BYTE_ENABLE_EN.
module pixel_pack_rgb888 #(
    parameter int ADDR_WIDTH = 32,
    parameter int ADDR_STEP  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pix_valid_i,
    output logic                  pix_ready_o,
    input  logic                  pix_last_i,
    input  logic [7:0]            data_r_i,
    input  logic [7:0]            data_g_i,
    input  logic [7:0]            data_b_i,
    input  logic [ADDR_WIDTH-1:0] base_addr_i,
    output logic                  word_valid_o,
    input  logic                  word_ready_i,
    output logic [31:0]           word_data_o,
    output logic [ADDR_WIDTH-1:0] word_addr_o,
`ifdef PACK_BYTE_ENABLE_EN
    output logic [3:0]            word_be_o,
`endif
    output logic                  word_last_o
);
    typedef enum logic {RUN, FLUSH} state_t;
    state_t                r_state, w_state_next;
    logic [1:0]            r_phase;
    logic [23:0]           r_res;
    logic                  r_first;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_word_valid, r_word_last;
    logic [31:0]           r_word_data;
    logic [ADDR_WIDTH-1:0] r_word_addr;
    logic                  w_free, w_accept, w_flush, w_pix_emit;
    logic [23:0]           w_pix, w_res_next;
    logic [31:0]           w_full;
    assign w_free     = ~r_word_valid | word_ready_i;
    assign w_accept   = pix_valid_i & pix_ready_o;
    assign w_pix_emit = w_accept & (r_phase != 2'd0);
    assign w_pix      = {data_b_i, data_g_i, data_r_i};
    // residue is kept zero-extended so a flush word is simply {8'h0, r_res}
    assign w_full     = (r_phase == 2'd1) ? {w_pix[7:0], r_res} :
                        (r_phase == 2'd2) ? {w_pix[15:0], r_res[15:0]} : {w_pix, r_res[7:0]};
    assign w_res_next = (r_phase == 2'd0) ? w_pix :
                        (r_phase == 2'd1) ? {8'h0, w_pix[23:8]} :
                        (r_phase == 2'd2) ? {16'h0, w_pix[23:16]} : 24'h0;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= RUN;
        else     r_state <= w_state_next;
    end
    always_comb begin
        w_state_next = (r_state == RUN) ?
                       ((w_accept && pix_last_i && r_phase != 2'd3) ? FLUSH : RUN) :
                       (w_free ? RUN : FLUSH);
    end
    always_comb begin
        pix_ready_o = ~rst & (r_state == RUN) & w_free;
        w_flush     = (r_state == FLUSH) & w_free;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_phase      <= 2'd0;
            r_res        <= 24'h0;
            r_first      <= 1'b1;
            r_addr       <= '0;
            r_word_valid <= 1'b0;
            r_word_data  <= 32'h0;
            r_word_addr  <= '0;
            r_word_last  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_phase <= r_phase + 2'd1;
                r_res   <= w_res_next;
                r_first <= pix_last_i;
                if (r_first) r_addr <= base_addr_i;
            end
            if (w_flush) begin
                r_phase <= 2'd0;
                r_res   <= 24'h0;
            end
            if (w_pix_emit || w_flush) begin
                r_word_valid <= 1'b1;
                r_word_data  <= w_flush ? {8'h0, r_res} : w_full;
                r_word_addr  <= r_addr;
                r_word_last  <= w_flush | (pix_last_i & (r_phase == 2'd3));
                r_addr       <= r_addr + ADDR_WIDTH'(ADDR_STEP);
            end else if (word_ready_i) begin
                r_word_valid <= 1'b0;
            end
        end
    end
`ifdef PACK_BYTE_ENABLE_EN
    logic [3:0] r_be;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                     r_be <= 4'b0000;
        else if (w_pix_emit)         r_be <= 4'b1111;
        else if (w_flush)            r_be <= (r_phase == 2'd1) ? 4'b0111 :
                                             (r_phase == 2'd2) ? 4'b0011 : 4'b0001;
    end
    assign word_be_o = r_be;
`endif
    assign word_valid_o = r_word_valid;
    assign word_data_o  = r_word_data;
    assign word_addr_o  = r_word_addr;
    assign word_last_o  = r_word_last;
endmodule
